// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag bundle and default width for the ALU_2 block.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned OPCODE_WIDTH  = 4;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_NOT    = 4'd5,
    OP_INC    = 4'd6,
    OP_DEC    = 4'd7,
    OP_SHL    = 4'd8,
    OP_SHR    = 4'd9,
    OP_SRA    = 4'd10,
    OP_ROL    = 4'd11,
    OP_ROR    = 4'd12,
    OP_MUL    = 4'd13,
    OP_PASS_A = 4'd14,
    OP_PASS_B = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU: next result and status flags from operands and opcode.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          opcode,
  output logic [WIDTH-1:0] result_c,
  output alu_flags_t       flags_c
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH:0]   ext;
  logic [PW-1:0]    prod;
  logic             a_msb;
  logic             b_msb;
  logic             r_msb;

  assign a_msb = a[WIDTH-1];
  assign b_msb = b[WIDTH-1];
  assign prod  = PW'(a) * PW'(b);

  // Arithmetic runs one bit wide so bit WIDTH is the carry or borrow.
  always_comb begin
    result_c         = '0;
    flags_c          = '0;
    ext              = '0;
    unique case (opcode)
      OP_ADD: begin
        ext              = {1'b0, a} + {1'b0, b};
        result_c         = ext[WIDTH-1:0];
        flags_c.carry    = ext[WIDTH];
        flags_c.overflow = (a_msb == b_msb) && (ext[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        ext              = {1'b0, a} - {1'b0, b};
        result_c         = ext[WIDTH-1:0];
        flags_c.carry    = ext[WIDTH];
        flags_c.overflow = (a_msb != b_msb) && (ext[WIDTH-1] != a_msb);
      end
      OP_INC: begin
        ext              = {1'b0, a} + (WIDTH+1)'(1);
        result_c         = ext[WIDTH-1:0];
        flags_c.carry    = ext[WIDTH];
        flags_c.overflow = !a_msb && ext[WIDTH-1];
      end
      OP_DEC: begin
        ext              = {1'b0, a} - (WIDTH+1)'(1);
        result_c         = ext[WIDTH-1:0];
        flags_c.carry    = ext[WIDTH];
        flags_c.overflow = a_msb && !ext[WIDTH-1];
      end
      OP_AND:    result_c = a & b;
      OP_OR:     result_c = a | b;
      OP_XOR:    result_c = a ^ b;
      OP_NOT:    result_c = ~a;
      OP_SHL: begin
        result_c      = {a[WIDTH-2:0], 1'b0};
        flags_c.carry = a[WIDTH-1];
      end
      OP_SHR: begin
        result_c      = {1'b0, a[WIDTH-1:1]};
        flags_c.carry = a[0];
      end
      OP_SRA: begin
        result_c      = {a[WIDTH-1], a[WIDTH-1:1]};
        flags_c.carry = a[0];
      end
      OP_ROL: begin
        result_c      = {a[WIDTH-2:0], a[WIDTH-1]};
        flags_c.carry = a[WIDTH-1];
      end
      OP_ROR: begin
        result_c      = {a[0], a[WIDTH-1:1]};
        flags_c.carry = a[0];
      end
      OP_MUL: begin
        result_c      = prod[WIDTH-1:0];
        flags_c.carry = |prod[PW-1:WIDTH];
      end
      OP_PASS_A: result_c = a;
      OP_PASS_B: result_c = b;
      default: begin
        result_c = '0;
        flags_c  = '0;
      end
    endcase
    flags_c.zero     = (result_c == '0);
    flags_c.negative = result_c[WIDTH-1];
    if (!((opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_INC) ||
          (opcode == OP_DEC) || (opcode == OP_SHL) || (opcode == OP_SHR) ||
          (opcode == OP_SRA) || (opcode == OP_ROL) || (opcode == OP_ROR) ||
          (opcode == OP_MUL) || (opcode == OP_AND) || (opcode == OP_OR)  ||
          (opcode == OP_XOR) || (opcode == OP_NOT) || (opcode == OP_PASS_A) ||
          (opcode == OP_PASS_B))) begin
      flags_c.zero     = 1'b0;
      flags_c.negative = 1'b0;
    end
  end

  assign r_msb = result_c[WIDTH-1];

  logic unused_ok;
  assign unused_ok = r_msb;

endmodule

// File: rtl/alu_core.sv
// Registered ALU: one-cycle latency, one op per cycle, outputs hold when idle.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [WIDTH-1:0]        result,
  output logic                    carry,
  output logic                    zero,
  output logic                    negative,
  output logic                    overflow,
  output logic                    out_valid
);

  logic [WIDTH-1:0] result_c;
  alu_flags_t       flags_c;

  alu_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .a        (a),
    .b        (b),
    .opcode   (alu_op_e'(opcode)),
    .result_c (result_c),
    .flags_c  (flags_c)
  );

  // Single output stage; result and flags only move on a valid input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= result_c;
        carry    <= flags_c.carry;
        zero     <= flags_c.zero;
        negative <= flags_c.negative;
        overflow <= flags_c.overflow;
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector and streaming self-check for alu_core (WIDTH = 8).
module tb_alu_core;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   opcode;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         negative;
  logic         overflow;
  logic         out_valid;

  int checks;
  int errors;

  alu_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_op_e      op;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         n;
    logic         v;
  } vec_t;

  // Packed view: {result, carry, zero, negative, overflow, out_valid}
  task automatic check(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {result, carry, zero, negative, overflow, out_valid};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got r=%h c=%b z=%b n=%b v=%b ov=%b expected r=%h c=%b z=%b n=%b v=%b ov=%b",
               name, act[12:5], act[4], act[3], act[2], act[1], act[0],
               exp[12:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input alu_op_e op, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vld);
    @(negedge clk);
    opcode   = op;
    a        = va;
    b        = vb;
    in_valid = vld;
  endtask

  // Reference model written in integer arithmetic.
  task automatic model(input alu_op_e op, input logic [W-1:0] va, input logic [W-1:0] vb,
                       output logic [12:0] exp);
    int ua, ub, sa, sb, s, ss;
    logic [W-1:0] r;
    logic c, v;
    ua = int'(va); ub = int'(vb);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin s = ua + ub; r = W'(s); c = (s > 255); ss = sa + sb; v = (ss > 127) || (ss < -128); end
      OP_SUB: begin s = ua - ub; r = W'(s); c = (ua < ub); ss = sa - sb; v = (ss > 127) || (ss < -128); end
      OP_INC: begin s = ua + 1; r = W'(s); c = (s > 255); v = (sa + 1 > 127); end
      OP_DEC: begin s = ua - 1; r = W'(s); c = (ua < 1); v = (sa - 1 < -128); end
      OP_AND: r = va & vb;
      OP_OR:  r = va | vb;
      OP_XOR: r = va ^ vb;
      OP_NOT: r = ~va;
      OP_SHL: begin r = W'(ua * 2); c = (ua >= 128); end
      OP_SHR: begin r = W'(ua / 2); c = (ua % 2 == 1); end
      OP_SRA: begin r = W'(ua / 2 + ((ua >= 128) ? 128 : 0)); c = (ua % 2 == 1); end
      OP_ROL: begin r = W'(ua * 2 + ((ua >= 128) ? 1 : 0)); c = (ua >= 128); end
      OP_ROR: begin r = W'(ua / 2 + ((ua % 2 == 1) ? 128 : 0)); c = (ua % 2 == 1); end
      OP_MUL: begin s = ua * ub; r = W'(s); c = (s > 255); end
      OP_PASS_A: r = va;
      OP_PASS_B: r = vb;
      default: r = '0;
    endcase
    exp = {r, c, (r == 8'h00), r[7], v, 1'b1};
  endtask

  vec_t vecs[$];
  logic [12:0] exp_q;
  logic [12:0] held;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; opcode = '0;

    vecs = '{
      '{OP_ADD,    8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1},
      '{OP_ADD,    8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
      '{OP_SUB,    8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0},
      '{OP_SUB,    8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1},
      '{OP_AND,    8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0},
      '{OP_OR,     8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0},
      '{OP_XOR,    8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0},
      '{OP_NOT,    8'h55, 8'h00, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0},
      '{OP_INC,    8'h7F, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1},
      '{OP_INC,    8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
      '{OP_DEC,    8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0},
      '{OP_DEC,    8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1},
      '{OP_SHL,    8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0},
      '{OP_SHR,    8'h81, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0},
      '{OP_SRA,    8'h81, 8'h00, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b0},
      '{OP_ROL,    8'h81, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0},
      '{OP_ROR,    8'h01, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0},
      '{OP_MUL,    8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0},
      '{OP_MUL,    8'h0F, 8'h03, 8'h2D, 1'b0, 1'b0, 1'b0, 1'b0},
      '{OP_PASS_A, 8'h9A, 8'h11, 8'h9A, 1'b0, 1'b0, 1'b1, 1'b0},
      '{OP_PASS_B, 8'h9A, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}
    };

    repeat (2) @(posedge clk);
    #1 check("reset_state", 13'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream after ADD 5+3
    drive(OP_ADD, 8'h05, 8'h03, 1'b1);
    @(posedge clk); #1 check("add_5_3", {8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    #2 rst_n = 1'b0;
    #1 check("async_reset", 13'h0);
    @(posedge clk); #1 check("reset_drops_op", 13'h0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 check("idle_after_reset", 13'h0);

    // Directed table
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].va, vecs[i].vb, 1'b1);
      @(posedge clk);
      #1 check($sformatf("vec%0d_%s", i, vecs[i].op.name()),
               {vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v, 1'b1});
    end

    // Gap: outputs hold, out_valid drops, new operands ignored
    held = {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    drive(OP_ADD, 8'h12, 8'h34, 1'b0);
    @(posedge clk); #1 check("gap_hold", held);
    drive(OP_NOT, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1 check("gap_hold2", held);

    // Streaming: every opcode back to back, random operands
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      drive(alu_op_e'(4'(i)), ra, rb, 1'b1);
      model(alu_op_e'(4'(i)), ra, rb, exp_q);
      @(posedge clk);
      #1 check($sformatf("stream_op%0d_a%h_b%h", i, ra, rb), exp_q);
    end

    held = exp_q;
    held[0] = 1'b0;
    drive(OP_SUB, 8'h01, 8'h02, 1'b0);
    @(posedge clk); #1 check("stream_gap_hold", held);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
